jtag_dbus_master: RTL and testbench

- Downstream consumer of the JTAG address user register (ADDR/WR/INC) in the debug path.
- Owns a second JTAG user data register (DR) and turns each DR update into one 32-bit system-bus read or write at the programmed address.
- Auto-increments the address when INC=1.
- Crosses accesses from the TCK domain to the CLK domain with a toggle handshake and returns read data and status on the next DR capture.

---
 rtl/jtag_dbus_pkg.sv | 15 +
 rtl/jtag_sync2.sv | 21 ++
 rtl/jtag_dbus_master.sv | 200 ++++++++++++++++++++
 tb/tb_jtag_dbus_master.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtag_dbus_pkg.sv
// Shared constants and types for the JTAG data-register bus master.
package jtag_dbus_pkg;

   localparam int DR_W      = 34;
   localparam int ERR_BIT   = 33;
   localparam int BUSY_BIT  = 32;
   localparam int ADDR_STEP = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      RESP = 2'd2
   } bus_state_t;

endpackage

// File: rtl/jtag_sync2.sv
// Single-bit flop-chain synchroniser with synchronous reset in the destination domain.
module jtag_sync2 #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] chain;

   // shift the asynchronous input through the chain
   always_ff @(posedge clk) begin
      if (reset) chain <= '0;
      else       chain <= (chain << 1) | STAGES'(d);
   end

   assign q = chain[STAGES-1];

endmodule

// File: rtl/jtag_dbus_master.sv
// JTAG data DR that issues one 32-bit bus access per DR update.
// Accesses cross TCK -> CLK with a request toggle and return with an ack toggle;
// the op_* fields are held stable while busy, so they cross without synchronisers.
//
// CLK-side bus FSM:
//   state | meaning
//   IDLE  | waiting for a new request toggle edge
//   REQ   | bus_req asserted, waiting for bus_gnt
//   RESP  | granted, waiting for bus_rvalid
module jtag_dbus_master
   import jtag_dbus_pkg::*;
#(
   parameter int DW          = 32,
   parameter int AW          = 32,
   parameter int SYNC_STAGES = 2
) (
   input  logic          TCK,
   input  logic          CLK,
   input  logic          RESET,
   input  logic          SEL,
   input  logic          CAPTURE,
   input  logic          SHIFT,
   input  logic          UPDATE,
   input  logic          TDI,
   output logic          TDO,
   input  logic [AW-1:0] ADDR,
   input  logic          WR,
   input  logic          INC,
   output logic          bus_req,
   output logic          bus_we,
   output logic [AW-1:0] bus_addr,
   output logic [DW-1:0] bus_wdata,
   output logic [3:0]    bus_be,
   input  logic          bus_gnt,
   input  logic          bus_rvalid,
   input  logic [DW-1:0] bus_rdata,
   input  logic          bus_err
);

   // TCK domain
   logic [DR_W-1:0] sr;
   logic [DR_W-1:0] cap_word;
   logic [AW-1:0]   addr_prev;
   logic [AW-1:0]   offset;
   logic [AW-1:0]   addr_sum;
   logic [AW-1:0]   eff_addr;
   logic            busy;
   logic            err;
   logic [DW-1:0]   rdata;
   logic            req_tgl;
   logic            op_we;
   logic [AW-1:0]   op_addr;
   logic [DW-1:0]   op_wdata;
   logic            ack_s;
   logic            ack_q;
   logic            ack_edge;
   logic            issue;
   logic            overrun;
   logic            capture;

   // CLK domain
   bus_state_t      state;
   bus_state_t      state_nxt;
   logic            req_s;
   logic            req_q;
   logic            req_edge;
   logic [DW-1:0]   rdata_c;
   logic            err_c;
   logic            ack_tgl;

   jtag_sync2 #(.STAGES(SYNC_STAGES)) u_req_sync (
      .clk   (CLK),
      .reset (RESET),
      .d     (req_tgl),
      .q     (req_s)
   );

   jtag_sync2 #(.STAGES(SYNC_STAGES)) u_ack_sync (
      .clk   (TCK),
      .reset (RESET),
      .d     (ack_tgl),
      .q     (ack_s)
   );

   assign capture  = SEL && CAPTURE;
   assign issue    = SEL && UPDATE && !busy;
   assign overrun  = SEL && UPDATE && busy;
   assign ack_edge = ack_s ^ ack_q;
   assign addr_sum = ADDR + offset;
   assign eff_addr = {addr_sum[AW-1:2], 2'b00};
   assign TDO      = sr[0];
   assign bus_be   = 4'hF;

   // capture word seen by the host: status on top, last read data below
   always_comb begin
      cap_word           = '0;
      cap_word[DW-1:0]   = rdata;
      cap_word[BUSY_BIT] = busy;
      cap_word[ERR_BIT]  = err;
   end

   // DR shift register: capture status/data, or shift LSB-first toward TDO
   always_ff @(posedge TCK) begin
      if (RESET)                sr <= '0;
      else if (capture)         sr <= cap_word;
      else if (SEL && SHIFT)    sr <= {TDI, sr[DR_W-1:1]};
   end

   // address tracking: a new base address restarts the increment offset
   always_ff @(posedge TCK) begin
      if (RESET) begin
         addr_prev <= '0;
         offset    <= '0;
      end else if (ADDR != addr_prev) begin
         addr_prev <= ADDR;
         offset    <= '0;
      end else if (issue && INC) begin
         offset    <= offset + AW'(ADDR_STEP);
      end
   end

   // issue, completion and sticky status in the TCK domain
   always_ff @(posedge TCK) begin
      if (RESET) begin
         busy     <= 1'b0;
         err      <= 1'b0;
         rdata    <= '0;
         req_tgl  <= 1'b0;
         op_we    <= 1'b0;
         op_addr  <= '0;
         op_wdata <= '0;
         ack_q    <= 1'b0;
      end else begin
         ack_q <= ack_s;
         if (issue) begin
            op_we    <= WR;
            op_addr  <= eff_addr;
            op_wdata <= sr[DW-1:0];
            req_tgl  <= ~req_tgl;
            busy     <= 1'b1;
         end else if (ack_edge) begin
            busy     <= 1'b0;
         end
         // capture clears, any set in the same edge wins
         err <= (capture ? 1'b0 : err) | overrun | (ack_edge & err_c);
         if (ack_edge) rdata <= rdata_c;
      end
   end

   assign req_edge = req_s ^ req_q;

   // bus FSM state register
   always_ff @(posedge CLK) begin
      if (RESET) state <= IDLE;
      else       state <= state_nxt;
   end

   // bus FSM next-state decode
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (req_edge)   state_nxt = REQ;
         REQ:     if (bus_gnt)    state_nxt = RESP;
         RESP:    if (bus_rvalid) state_nxt = IDLE;
         default:                 state_nxt = IDLE;
      endcase
   end

   // bus FSM outputs
   always_comb begin
      bus_req = 1'b0;
      if (state == REQ) bus_req = 1'b1;
   end

   // CLK-side datapath: latch the op on request, return the response by toggle
   always_ff @(posedge CLK) begin
      if (RESET) begin
         req_q     <= 1'b0;
         bus_we    <= 1'b0;
         bus_addr  <= '0;
         bus_wdata <= '0;
         rdata_c   <= '0;
         err_c     <= 1'b0;
         ack_tgl   <= 1'b0;
      end else begin
         req_q <= req_s;
         if (state == IDLE && req_edge) begin
            bus_we    <= op_we;
            bus_addr  <= op_addr;
            bus_wdata <= op_wdata;
         end
         if (state == RESP && bus_rvalid) begin
            if (!bus_we) rdata_c <= bus_rdata;
            err_c   <= bus_err;
            ack_tgl <= ~ack_tgl;
         end
      end
   end

endmodule

// File: tb/tb_jtag_dbus_master.sv
// Bench for jtag_dbus_master: DR scans from the host side, a bus responder on CLK,
// and a transaction-level model of address, busy, err and read data.
module tb_jtag_dbus_master;

   logic        TCK, CLK, RESET;
   logic        SEL, CAPTURE, SHIFT, UPDATE, TDI, TDO;
   logic [31:0] ADDR;
   logic        WR, INC;
   logic        bus_req, bus_we;
   logic [31:0] bus_addr, bus_wdata;
   logic [3:0]  bus_be;
   logic        bus_gnt, bus_rvalid, bus_err;
   logic [31:0] bus_rdata;

   jtag_dbus_master #(.DW(32), .AW(32), .SYNC_STAGES(2)) dut (
      .TCK(TCK), .CLK(CLK), .RESET(RESET),
      .SEL(SEL), .CAPTURE(CAPTURE), .SHIFT(SHIFT), .UPDATE(UPDATE),
      .TDI(TDI), .TDO(TDO),
      .ADDR(ADDR), .WR(WR), .INC(INC),
      .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
      .bus_wdata(bus_wdata), .bus_be(bus_be),
      .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid),
      .bus_rdata(bus_rdata), .bus_err(bus_err)
   );

   initial begin TCK = 1'b0; forever #20 TCK = ~TCK; end
   initial begin CLK = 1'b0; #5; forever #5 CLK = ~CLK; end

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
   endtask

   // responder controls (written by the stimulus only)
   bit          hold = 1'b1;
   int          gnt_wait = 0;
   int          rv_wait = 0;
   logic [31:0] resp_data = '0;
   bit          resp_err = 1'b0;
   int          late_req = 0;

   // responder state (written by the responder only)
   int done_cnt = 0;
   int late_done = 0;

   // transaction log (written by the monitor only)
   logic        obs_we[64];
   logic [31:0] obs_addr[64];
   logic [31:0] obs_wdata[64];
   logic [3:0]  obs_be[64];
   int          obs_n = 0;
   bit          req_seen = 1'b0;

   always begin
      @(negedge CLK);
      if (bus_req && !req_seen) begin
         if (obs_n < 64) begin
            obs_we[obs_n]    = bus_we;
            obs_addr[obs_n]  = bus_addr;
            obs_wdata[obs_n] = bus_wdata;
            obs_be[obs_n]    = bus_be;
         end
         obs_n++;
      end
      req_seen = bus_req;
   end

   initial begin
      bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_err = 1'b0; bus_rdata = '0;
   end

   always begin
      @(negedge CLK);
      if (late_req != late_done) begin
         bus_gnt = 1'b1; bus_rvalid = 1'b1; bus_rdata = 32'hBAD0_BAD0; bus_err = 1'b1;
         @(negedge CLK);
         bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_err = 1'b0;
         late_done++;
      end else if (bus_req && !hold) begin
         repeat (gnt_wait) @(negedge CLK);
         bus_gnt = 1'b1;
         @(negedge CLK);
         bus_gnt = 1'b0;
         repeat (rv_wait) @(negedge CLK);
         bus_rvalid = 1'b1; bus_rdata = resp_data; bus_err = resp_err;
         @(negedge CLK);
         bus_rvalid = 1'b0; bus_err = 1'b0;
         done_cnt++;
      end
   end

   // reference model state
   bit          busy_m = 1'b0;
   bit          err_m = 1'b0;
   logic [31:0] rdata_m = '0;
   logic [31:0] off_m = '0;
   bit          pend_we;
   logic [31:0] pend_addr, pend_wdata;
   int          done_exp = 0;
   int          rd_idx = 0;

   task automatic set_addr(input logic [31:0] a);
      if (a != ADDR) off_m = '0;
      ADDR = a;
   endtask

   task automatic scan(input logic [33:0] din, input bit upd, output logic [33:0] dout);
      dout = '0;
      @(negedge TCK); SEL = 1'b1; CAPTURE = 1'b1; SHIFT = 1'b0; UPDATE = 1'b0;
      @(negedge TCK); CAPTURE = 1'b0; SHIFT = 1'b1;
      for (int i = 0; i < 34; i++) begin
         dout[i] = TDO;
         TDI = din[i];
         @(negedge TCK);
      end
      SHIFT = 1'b0; UPDATE = upd;
      @(negedge TCK); UPDATE = 1'b0; SEL = 1'b0;
   endtask

   task automatic access(input bit upd, input logic [31:0] wdata);
      logic [33:0] cap;
      logic [33:0] din;
      din = {2'($urandom_range(0, 3)), wdata};
      scan(din, upd, cap);
      check_eq("capture", cap, {err_m, busy_m, rdata_m});
      err_m = 1'b0;
      if (upd) begin
         if (busy_m) err_m = 1'b1;
         else begin
            pend_we    = WR;
            pend_addr  = (ADDR + off_m) & 32'hFFFF_FFFC;
            pend_wdata = wdata;
            busy_m     = 1'b1;
            if (INC) off_m = off_m + 32'd4;
         end
      end
   endtask

   task automatic wait_req(input int n);
      int t = 0;
      while (obs_n < n && t < 200) begin @(negedge CLK); t++; end
      check_eq("req_seen", obs_n, n);
   endtask

   task automatic complete();
      int t = 0;
      done_exp++;
      while (done_cnt < done_exp && t < 400) begin @(negedge CLK); t++; end
      check_eq("resp_done", done_cnt, done_exp);
      repeat (8) @(negedge TCK);
      busy_m = 1'b0;
      if (!pend_we) rdata_m = resp_data;
      err_m = err_m | resp_err;
      check_eq("txn_seen", obs_n > rd_idx, 1);
      if (obs_n > rd_idx && rd_idx < 64) begin
         check_eq("bus_we", obs_we[rd_idx], pend_we);
         check_eq("bus_addr", obs_addr[rd_idx], pend_addr);
         check_eq("bus_wdata", obs_wdata[rd_idx], pend_wdata);
         check_eq("bus_be", obs_be[rd_idx], 4'hF);
      end
      rd_idx++;
   endtask

   initial begin
      #500us;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int n0;
      RESET = 1'b1; SEL = 1'b0; CAPTURE = 1'b0; SHIFT = 1'b0; UPDATE = 1'b0; TDI = 1'b0;
      ADDR = '0; WR = 1'b0; INC = 1'b0;
      repeat (4) @(negedge TCK);
      RESET = 1'b0;
      @(negedge TCK);
      check_eq("rst_tdo", TDO, 0);
      check_eq("rst_req", bus_req, 0);
      check_eq("rst_we", bus_we, 0);
      check_eq("rst_addr", bus_addr, 0);
      check_eq("rst_wdata", bus_wdata, 0);
      check_eq("rst_be", bus_be, 4'hF);
      hold = 1'b0;

      // single write, then stale read data with busy clear
      set_addr(32'h1000); WR = 1'b1; INC = 1'b0; gnt_wait = 0; rv_wait = 1;
      resp_data = 32'h5555_AAAA;
      access(1'b1, 32'hDEAD_BEEF); complete();
      access(1'b0, 32'h0);

      // read with a three-cycle grant wait
      set_addr(32'h2000); WR = 1'b0; gnt_wait = 3; resp_data = 32'h1234_5678;
      access(1'b1, $urandom); complete();
      access(1'b0, 32'h0);

      // auto-increment, base change, and wrap past the top of the address space
      set_addr(32'h3000); WR = 1'b1; INC = 1'b1; gnt_wait = 1;
      for (int i = 0; i < 3; i++) begin access(1'b1, $urandom); complete(); end
      set_addr(32'h4000);
      access(1'b1, $urandom); complete();
      set_addr(32'hFFFF_FFFC);
      for (int i = 0; i < 2; i++) begin access(1'b1, $urandom); complete(); end

      // overrun while the grant is withheld
      INC = 1'b0; hold = 1'b1; gnt_wait = 0;
      access(1'b1, $urandom);
      wait_req(rd_idx + 1);
      access(1'b1, $urandom);
      access(1'b0, 32'h0);
      repeat (20) @(negedge CLK);
      check_eq("overrun_one_req", obs_n, rd_idx + 1);
      hold = 1'b0;
      complete();
      access(1'b0, 32'h0);

      // bus error on a read is reported once
      WR = 1'b0; resp_err = 1'b1; resp_data = 32'hCAFE_F00D;
      access(1'b1, $urandom); complete();
      resp_err = 1'b0;
      access(1'b0, 32'h0);
      access(1'b0, 32'h0);

      // reset while the request is outstanding, then a stray late response
      hold = 1'b1; set_addr(32'h5000);
      access(1'b1, $urandom);
      wait_req(rd_idx + 1);
      @(negedge TCK); RESET = 1'b1;
      @(posedge CLK); #1;
      check_eq("rst_mid_req", bus_req, 0);
      repeat (4) @(negedge TCK);
      RESET = 1'b0;
      @(negedge TCK);
      check_eq("rst_mid_tdo", TDO, 0);
      busy_m = 1'b0; err_m = 1'b0; rdata_m = '0; off_m = '0;
      rd_idx++;
      hold = 1'b0;
      n0 = obs_n;
      late_req++;
      repeat (10) @(negedge CLK);
      check_eq("late_no_req", obs_n, n0);
      access(1'b0, 32'h0);
      resp_data = 32'h0BAD_F00D;
      access(1'b1, $urandom); complete();
      access(1'b0, 32'h0);

      // randomized accesses
      for (int k = 0; k < 20; k++) begin
         if ($urandom_range(0, 3) == 0) begin
            case ($urandom_range(0, 2))
               0: set_addr($urandom);
               1: set_addr(32'hFFFF_FFF8 | 32'($urandom_range(0, 3)));
               default: set_addr(32'($urandom_range(0, 255)) << 4);
            endcase
         end
         WR = 1'($urandom_range(0, 1));
         INC = 1'($urandom_range(0, 1));
         gnt_wait = $urandom_range(0, 4);
         rv_wait = $urandom_range(0, 3);
         resp_data = $urandom;
         resp_err = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 4) == 0) access(1'b0, 32'h0);
         access(1'b1, $urandom);
         complete();
      end
      access(1'b0, 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
